// File: rtl/fir_datapath_mc_pkg.sv
// Shared types for the multi-channel FIR engine: FSM states, job control
// word and status flags.
package fir_datapath_mc_pkg;

    typedef enum logic [1:0] {
        FSM_MC_IDLE     = 2'd0,
        FSM_MC_TAP_LOAD = 2'd1,
        FSM_MC_COMPUTE  = 2'd2
    } fir_mc_fsm_state_t;

    typedef struct packed {
        logic [5:0]  right_shift;
        logic        round_en;
        logic        sat_en;
        logic [15:0] signal_length;
    } fir_mc_ctrl_t;

    typedef struct packed {
        logic busy;
        logic done;
    } fir_mc_flags_t;

endpackage

// File: rtl/fir_datapath_mc_lane.sv
// One FIR lane: delay line, MAC over the shared taps, accumulator stage and
// requantised output register. The accumulator moves on an accepted x beat,
// the output register on adv while the accumulator holds a valid result.
module fir_mc_lane #(
    parameter int NB_TAPS     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic                           x_fire_i,
    input  logic                           adv_i,
    input  logic                           acc_vld_i,
    input  logic [5:0]                     right_shift_i,
    input  logic                           round_en_i,
    input  logic                           sat_en_i,
    input  logic [NB_TAPS*COEFF_WIDTH-1:0] taps_i,
    input  logic [DATA_WIDTH-1:0]          x_i,
    output logic [DATA_WIDTH-1:0]          y_o
);

    localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(NB_TAPS);
    localparam int EXT_W     = ACC_WIDTH + 1;
    localparam int DL_N      = (NB_TAPS > 1) ? NB_TAPS - 1 : 1;
    // Saturation bounds, sign-extended to the rounding width.
    localparam logic signed [EXT_W-1:0] Y_MAX =
        {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Y_MIN =
        {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0]             dl_q [DL_N];
    logic signed [DATA_WIDTH-1:0]             win [NB_TAPS];
    logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]              sum_d;
    logic signed [ACC_WIDTH-1:0]              acc_q;
    logic signed [EXT_W-1:0]                  ext;
    logic signed [EXT_W-1:0]                  bias;
    logic signed [EXT_W-1:0]                  shifted;
    logic [DATA_WIDTH-1:0]                    req_d;
    logic [DATA_WIDTH-1:0]                    y_q;
    int                                       s;

    // Sample window: tap 0 sees the incoming sample, tap k the k-th older one.
    always_comb begin
        win[0] = x_i;
        for (int k = 1; k < NB_TAPS; k++) begin
            win[k] = dl_q[k-1];
        end
    end

    // Signed MAC over the window; full-width products are sign-extended.
    always_comb begin
        sum_d = '0;
        prod  = '0;
        for (int k = 0; k < NB_TAPS; k++) begin
            prod  = win[k] * $signed(taps_i[k*COEFF_WIDTH +: COEFF_WIDTH]);
            sum_d = sum_d + ACC_WIDTH'(prod);
        end
    end

    // Accumulator stage and delay line advance together on an accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            acc_q <= '0;
            for (int k = 0; k < DL_N; k++) begin
                dl_q[k] <= '0;
            end
        end else if (x_fire_i) begin
            acc_q   <= sum_d;
            dl_q[0] <= win[0];
            for (int k = 1; k < DL_N; k++) begin
                dl_q[k] <= dl_q[k-1];
            end
        end
    end

    // Requantise: clamp the shift, optional round-half-up, then saturate or wrap.
    always_comb begin
        s = (int'(right_shift_i) > ACC_WIDTH - 1) ? ACC_WIDTH - 1 : int'(right_shift_i);
        ext  = {acc_q[ACC_WIDTH-1], acc_q};
        bias = '0;
        if (round_en_i && (s > 0)) begin
            bias = EXT_W'(1) <<< (s - 1);
        end
        shifted = (ext + bias) >>> s;
        req_d   = shifted[DATA_WIDTH-1:0];
        if (sat_en_i) begin
            if (shifted > Y_MAX) begin
                req_d = Y_MAX[DATA_WIDTH-1:0];
            end else if (shifted < Y_MIN) begin
                req_d = Y_MIN[DATA_WIDTH-1:0];
            end
        end
    end

    // Output register loads when the output slot is free and a result is pending.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            y_q <= '0;
        end else if (adv_i && acc_vld_i) begin
            y_q <= req_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/fir_datapath_mc.sv
// Multi-channel direct-form FIR engine: loads NB_TAPS shared taps from the h
// stream, then filters NB_CH parallel x lanes into requantised y samples.
//
// Handshakes: every stream transfers on valid && ready at the clock edge; a
// producer that raises valid keeps it high with stable data until ready.
// y_valid_o and y_data_o are registered and hold while y_ready_i is low.
module fir_datapath_mc
    import fir_datapath_mc_pkg::*;
#(
    parameter int NB_CH       = 2,
    parameter int NB_TAPS     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  fir_mc_ctrl_t                ctrl_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        h_valid_i,
    output logic                        h_ready_o,
    input  logic [COEFF_WIDTH-1:0]      h_data_i,
    input  logic                        x_valid_i,
    output logic                        x_ready_o,
    input  logic [NB_CH*DATA_WIDTH-1:0] x_data_i,
    output logic                        y_valid_o,
    input  logic                        y_ready_i,
    output logic [NB_CH*DATA_WIDTH-1:0] y_data_o,
    output fir_mc_fsm_state_t           dbg_state_o
);

    localparam int TIDX_W = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1;

    fir_mc_fsm_state_t              state_q;
    fir_mc_ctrl_t                   ctrl_q;
    fir_mc_flags_t                  flags;
    logic [NB_TAPS*COEFF_WIDTH-1:0] taps_q;
    logic [TIDX_W-1:0]              tap_idx_q;
    logic [15:0]                    in_cnt_q;
    logic [15:0]                    out_cnt_q;
    logic                           acc_vld_q;
    logic                           y_valid_q;
    logic                           done_q;
    logic                           adv;
    logic                           start_fire;
    logic                           x_fire;
    logic                           y_fire;
    logic                           last_tap;
    logic                           last_y;

    // The pipeline may advance when the output slot is empty or being drained.
    assign adv        = !y_valid_q || y_ready_i;
    assign start_fire = (state_q == FSM_MC_IDLE) && start_i;
    assign h_ready_o  = (state_q == FSM_MC_TAP_LOAD);
    assign x_ready_o  = (state_q == FSM_MC_COMPUTE) && adv &&
                        (in_cnt_q < ctrl_q.signal_length);
    assign x_fire     = x_valid_i && x_ready_o;
    assign y_fire     = y_valid_q && y_ready_i;
    assign last_tap   = (tap_idx_q == TIDX_W'(NB_TAPS - 1));
    assign last_y     = (out_cnt_q == ctrl_q.signal_length - 16'd1);

    assign flags       = '{busy: (state_q != FSM_MC_IDLE), done: done_q};
    assign busy_o      = flags.busy;
    assign done_o      = flags.done;
    assign y_valid_o   = y_valid_q;
    assign dbg_state_o = state_q;

    // Job FSM with tap regfile, beat counters and pipeline valid flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FSM_MC_IDLE;
            ctrl_q    <= '0;
            taps_q    <= '0;
            tap_idx_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            acc_vld_q <= 1'b0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                FSM_MC_IDLE: begin
                    if (start_i) begin
                        ctrl_q    <= ctrl_i;
                        tap_idx_q <= '0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        acc_vld_q <= 1'b0;
                        y_valid_q <= 1'b0;
                        state_q   <= FSM_MC_TAP_LOAD;
                    end
                end
                FSM_MC_TAP_LOAD: begin
                    if (h_valid_i) begin
                        taps_q[tap_idx_q*COEFF_WIDTH +: COEFF_WIDTH] <= h_data_i;
                        tap_idx_q <= tap_idx_q + 1'b1;
                        if (last_tap) begin
                            tap_idx_q <= '0;
                            if (ctrl_q.signal_length == 16'd0) begin
                                done_q  <= 1'b1;
                                state_q <= FSM_MC_IDLE;
                            end else begin
                                state_q <= FSM_MC_COMPUTE;
                            end
                        end
                    end
                end
                FSM_MC_COMPUTE: begin
                    if (x_fire) begin
                        in_cnt_q <= in_cnt_q + 16'd1;
                    end
                    if (adv) begin
                        acc_vld_q <= x_fire;
                        y_valid_q <= acc_vld_q;
                    end
                    if (y_fire) begin
                        out_cnt_q <= out_cnt_q + 16'd1;
                        if (last_y) begin
                            done_q  <= 1'b1;
                            state_q <= FSM_MC_IDLE;
                        end
                    end
                end
                default: state_q <= FSM_MC_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NB_CH; c++) begin : g_lane
        fir_mc_lane #(
            .NB_TAPS     (NB_TAPS),
            .DATA_WIDTH  (DATA_WIDTH),
            .COEFF_WIDTH (COEFF_WIDTH)
        ) u_lane (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .clr_i         (start_fire),
            .x_fire_i      (x_fire),
            .adv_i         (adv),
            .acc_vld_i     (acc_vld_q),
            .right_shift_i (ctrl_q.right_shift),
            .round_en_i    (ctrl_q.round_en),
            .sat_en_i      (ctrl_q.sat_en),
            .taps_i        (taps_q),
            .x_i           (x_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .y_o           (y_data_o[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_fir_datapath_mc.sv
// Bench for fir_datapath_mc: directed table of known-answer jobs, randomised
// jobs against a plain-arithmetic convolution model, zero-length job and a
// mid-job reset.
module tb_fir_datapath_mc;
    import fir_datapath_mc_pkg::*;

    localparam int NB_CH   = 2;
    localparam int NB_TAPS = 4;
    localparam int DW      = 16;
    localparam int CW      = 16;
    localparam int YW      = NB_CH * DW;
    localparam int ACC_W   = DW + CW + $clog2(NB_TAPS);

    typedef int arr4_t [4];
    typedef int arr6_t [6];
    typedef struct {
        arr4_t taps;
        int    shift;
        bit    rnd;
        bit    sat;
        int    len;
        arr6_t x0;
        arr6_t x1;
        arr6_t y0;
        arr6_t y1;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, start, busy, done;
    fir_mc_ctrl_t      ctrl;
    logic              h_valid, h_ready;
    logic [CW-1:0]     h_data;
    logic              x_valid, x_ready;
    logic [YW-1:0]     x_data;
    logic              y_valid, y_ready;
    logic [YW-1:0]     y_data;
    fir_mc_fsm_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int first_x_cyc, first_yv_cyc, last_tap_cyc;
    int jx0[$];
    int jx1[$];
    logic [YW-1:0] exp_q[$];
    vec_t vecs [6];

    fir_datapath_mc #(
        .NB_CH(NB_CH), .NB_TAPS(NB_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
        .busy_o(busy), .done_o(done),
        .h_valid_i(h_valid), .h_ready_o(h_ready), .h_data_i(h_data),
        .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
        .y_valid_o(y_valid), .y_ready_i(y_ready), .y_data_o(y_data),
        .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [YW-1:0] pack2(input int a, input int b);
        logic [DW-1:0] la, lb;
        la = DW'(a);
        lb = DW'(b);
        return {lb, la};
    endfunction

    // Reference requantisation, straight from the arithmetic definition.
    function automatic int ref_requant(input longint acc, input int shift, input bit rnd, input bit sat);
        int     s;
        longint v;
        s = (shift > ACC_W - 1) ? ACC_W - 1 : shift;
        v = acc;
        if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (sat) begin
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
        end else begin
            v = v & 64'hFFFF;
            if (v >= 32768) v = v - 65536;
        end
        return int'(v);
    endfunction

    // Reference model: y[n] = requant(sum_k tap[k] * x[n-k]) per lane.
    task automatic build_exp(input arr4_t t, input fir_mc_ctrl_t c);
        int     len;
        int     y [NB_CH];
        longint acc;
        len = int'(c.signal_length);
        for (int n = 0; n < len; n++) begin
            for (int l = 0; l < NB_CH; l++) begin
                acc = 0;
                for (int k = 0; k < NB_TAPS; k++) begin
                    if (n - k >= 0) acc += longint'(t[k]) * longint'((l == 0) ? jx0[n-k] : jx1[n-k]);
                end
                y[l] = ref_requant(acc, int'(c.right_shift), c.round_en, c.sat_en);
            end
            exp_q.push_back(pack2(y[0], y[1]));
        end
    endtask

    task automatic do_start(input fir_mc_ctrl_t c);
        @(negedge clk);
        start = 1'b1;
        ctrl  = c;
        @(negedge clk);
        start = 1'b0;
        ctrl  = fir_mc_ctrl_t'(~c);
        check("busy_after_start", busy, 1);
        check("state_tap_load", dbg_state, FSM_MC_TAP_LOAD);
    endtask

    task automatic load_taps(input arr4_t t);
        for (int k = 0; k < NB_TAPS; k++) begin
            @(negedge clk);
            h_valid = 1'b1;
            h_data  = CW'(t[k]);
            #1;
            check("h_ready_tap_load", h_ready, 1);
        end
        last_tap_cyc = cyc;
    endtask

    // Drives x beats, randomises y_ready, scores y beats and the done pulse.
    task automatic run_compute(input int len, input int rdy_pct, input int xv_pct);
        int xi, yn, budget, last_yf_cyc, viol;
        bit xf, yf, done_seen;
        xi = 0; yn = 0; budget = 0; last_yf_cyc = -10; viol = 0;
        xf = 1'b0; done_seen = 1'b0;
        first_x_cyc = -1; first_yv_cyc = -1;
        while (budget < 3000) begin
            @(negedge clk);
            budget++;
            if (xf) xi++;
            if (done) begin
                done_seen = 1'b1;
                start = 1'b0; h_valid = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
                check("done_after_all_y", yn, len);
                check("done_timing", cyc - 1, (len == 0) ? last_tap_cyc : last_yf_cyc);
                break;
            end
            start   = ($urandom_range(0, 99) < 10);
            h_valid = ($urandom_range(0, 99) < 25);
            h_data  = CW'($urandom);
            if (!(x_valid && !xf)) begin
                if (xi < len && $urandom_range(0, 99) < xv_pct) begin
                    x_valid = 1'b1;
                    x_data  = pack2(jx0[xi], jx1[xi]);
                end else begin
                    x_valid = 1'b0;
                    x_data  = YW'($urandom);
                end
            end
            y_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (y_valid && !y_ready && x_ready) viol++;
            if (x_ready && xi >= len) viol++;
            xf = x_valid && x_ready;
            if (xf && first_x_cyc < 0) first_x_cyc = cyc;
            if (y_valid && first_yv_cyc < 0) first_yv_cyc = cyc;
            yf = y_valid && y_ready;
            if (yf) begin
                if (exp_q.size() == 0) begin
                    check("y_unexpected_beat", 1, 0);
                end else begin
                    check("y_data", y_data, exp_q.pop_front());
                end
                yn++;
                last_yf_cyc = cyc;
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        check("ready_invariants", viol, 0);
        check("exp_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_after_done", dbg_state, FSM_MC_IDLE);
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        fir_mc_ctrl_t c;
        jx0.delete(); jx1.delete(); exp_q.delete();
        for (int n = 0; n < v.len; n++) begin
            jx0.push_back(v.x0[n]);
            jx1.push_back(v.x1[n]);
            exp_q.push_back(pack2(v.y0[n], v.y1[n]));
        end
        c.right_shift   = 6'(v.shift);
        c.round_en      = v.rnd;
        c.sat_en        = v.sat;
        c.signal_length = 16'(v.len);
        do_start(c);
        load_taps(v.taps);
        run_compute(v.len, 100, 100);
        check("latency_first_y", first_yv_cyc - first_x_cyc, 2);
    endtask

    task automatic run_random(input int len, input int rdy_pct, input int xv_pct);
        fir_mc_ctrl_t c;
        arr4_t t;
        jx0.delete(); jx1.delete(); exp_q.delete();
        for (int k = 0; k < NB_TAPS; k++) t[k] = int'($urandom_range(0, 65535)) - 32768;
        for (int n = 0; n < len; n++) begin
            jx0.push_back(int'($urandom_range(0, 65535)) - 32768);
            jx1.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
        c.right_shift   = 6'($urandom_range(8, 40));
        c.round_en      = 1'($urandom_range(0, 1));
        c.sat_en        = 1'($urandom_range(0, 1));
        c.signal_length = 16'(len);
        build_exp(t, c);
        do_start(c);
        load_taps(t);
        run_compute(len, rdy_pct, xv_pct);
    endtask

    initial begin
        fir_mc_ctrl_t c;
        arr4_t t;
        vecs[0] = '{'{1, 0, 0, 0}, 0, 1'b0, 1'b0, 3,
                    '{5, 7, -3, 0, 0, 0}, '{1, 2, 3, 0, 0, 0},
                    '{5, 7, -3, 0, 0, 0}, '{1, 2, 3, 0, 0, 0}};
        vecs[1] = '{'{1, 2, 3, 4}, 0, 1'b0, 1'b1, 5,
                    '{1, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0},
                    '{1, 2, 3, 4, 0, 0}, '{2, 4, 6, 8, 0, 0}};
        vecs[2] = '{'{16384, 16384, 0, 0}, 14, 1'b0, 1'b1, 2,
                    '{32767, 32767, 0, 0, 0, 0}, '{-32768, -32768, 0, 0, 0, 0},
                    '{32767, 32767, 0, 0, 0, 0}, '{-32768, -32768, 0, 0, 0, 0}};
        vecs[3] = '{'{16384, 16384, 0, 0}, 14, 1'b0, 1'b0, 2,
                    '{32767, 32767, 0, 0, 0, 0}, '{-32768, -32768, 0, 0, 0, 0},
                    '{32767, -2, 0, 0, 0, 0}, '{-32768, 0, 0, 0, 0, 0}};
        vecs[4] = '{'{1, 0, 0, 0}, 1, 1'b1, 1'b0, 2,
                    '{3, -3, 0, 0, 0, 0}, '{5, -5, 0, 0, 0, 0},
                    '{2, -1, 0, 0, 0, 0}, '{3, -2, 0, 0, 0, 0}};
        vecs[5] = '{'{1, 0, 0, 0}, 1, 1'b0, 1'b0, 2,
                    '{3, -3, 0, 0, 0, 0}, '{5, -5, 0, 0, 0, 0},
                    '{1, -2, 0, 0, 0, 0}, '{2, -3, 0, 0, 0, 0}};

        rst = 1'b1; start = 1'b0; ctrl = '0;
        h_valid = 1'b0; h_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, h_ready, x_ready, y_valid, y_data}, 0);
        check("reset_state", dbg_state, FSM_MC_IDLE);

        // Directed known-answer jobs.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Zero-length job: done right after the last tap, no x accepted.
        jx0.delete(); jx1.delete(); exp_q.delete();
        c = '{right_shift: 6'd0, round_en: 1'b0, sat_en: 1'b0, signal_length: 16'd0};
        t = '{7, 6, 5, 4};
        do_start(c);
        load_taps(t);
        run_compute(0, 100, 100);

        // Randomised jobs with back-pressure.
        run_random(64, 60, 80);
        run_random(40, 30, 100);

        // Reset in the middle of a job with a y beat pending.
        c = '{right_shift: 6'd0, round_en: 1'b0, sat_en: 1'b1, signal_length: 16'd5};
        do_start(c);
        load_taps(vecs[1].taps);
        @(negedge clk);
        h_valid = 1'b0; y_ready = 1'b0; x_valid = 1'b1; x_data = pack2(1, 2);
        repeat (3) begin
            @(negedge clk);
            x_data = pack2(0, 0);
        end
        check("y_valid_before_reset", y_valid, 1);
        rst = 1'b1; x_valid = 1'b0;
        @(negedge clk);
        check("midjob_reset_outputs", {busy, done, h_ready, x_ready, y_valid, y_data}, 0);
        check("midjob_reset_state", dbg_state, FSM_MC_IDLE);
        rst = 1'b0;
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
